line_clear_ctrl: RTL

LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

---
 rtl/line_clear_ctrl_if.sv | 34 +++
 rtl/line_clear_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/line_clear_ctrl_if.sv
// Board-port and control bundle between the line-clear controller and its environment.
// The controller side drives the memory address/strobes and status; the environment drives the rest.
interface line_clear_ctrl_if;
  logic       start;
  logic       mem_rdata;
  logic [8:0] mem_addr;
  logic       mem_we;
  logic       mem_wdata;
  logic       busy;
  logic       done;
  logic [4:0] lines_cleared;

  modport master (
    input  start,
    input  mem_rdata,
    output mem_addr,
    output mem_we,
    output mem_wdata,
    output busy,
    output done,
    output lines_cleared
  );

  modport slave (
    output start,
    output mem_rdata,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    input  busy,
    input  done,
    input  lines_cleared
  );
endinterface

// File: rtl/line_clear_ctrl.sv
// Line-clear pass for a ROWS x COLS board: removes full rows bottom-up, compacts the rest
// toward the bottom row and zeroes the vacated top rows.
module line_clear_ctrl #(
  parameter int unsigned COLS = 10,
  parameter int unsigned ROWS = 20
) (
  input logic               clk,
  input logic               rst,
  line_clear_ctrl_if.master bus_io
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = $clog2(COLS + 1);
  localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);
  localparam logic [CW-1:0] ColLast = CW'(COLS - 1);
  localparam logic [CW-1:0] ColEnd  = CW'(COLS);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StEval,
    StWrite,
    StClear,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     r_q, r_d;
  logic [RW-1:0]     w_q, w_d;
  logic [CW-1:0]     col_q, col_d;
  logic [4:0]        lines_q, lines_d;
  logic [COLS-1:0]   row_buf_q, row_buf_d;

  logic       advance;
  logic [8:0] addr;
  logic       we;
  logic       wdata;
  logic       done;

  function automatic logic [8:0] cell_addr(input logic [RW-1:0] row, input logic [CW-1:0] col);
    return 9'(row) * 9'(COLS) + 9'(col);
  endfunction

  function automatic logic [RW-1:0] dec_sat(input logic [RW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    w_d       = w_q;
    col_d     = col_q;
    lines_d   = lines_q;
    row_buf_d = row_buf_q;
    advance   = 1'b0;
    addr      = '0;
    we        = 1'b0;
    wdata     = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          r_d     = RowLast;
          w_d     = RowLast;
          lines_d = '0;
          col_d   = '0;
          state_d = StRead;
        end
      end

      StRead: begin
        if (col_q < ColEnd) begin
          addr = cell_addr(r_q, col_q);
        end
        // Read data trails the address by one cycle; shifting in from the top leaves col 0 at bit 0.
        if (col_q != '0) begin
          row_buf_d = {bus_io.mem_rdata, row_buf_q[COLS-1:1]};
        end
        if (col_q == ColEnd) begin
          col_d   = '0;
          state_d = StEval;
        end else begin
          col_d = CW'(col_q + 1'b1);
        end
      end

      StEval: begin
        if (&row_buf_q) begin
          lines_d = 5'(lines_q + 5'd1);
          advance = 1'b1;
        end else if (w_q == r_q) begin
          w_d     = dec_sat(w_q);
          advance = 1'b1;
        end else begin
          col_d   = '0;
          state_d = StWrite;
        end
      end

      StWrite: begin
        we        = 1'b1;
        addr      = cell_addr(w_q, col_q);
        wdata     = row_buf_q[0];
        row_buf_d = {1'b0, row_buf_q[COLS-1:1]};
        if (col_q == ColLast) begin
          w_d     = dec_sat(w_q);
          advance = 1'b1;
        end else begin
          col_d = CW'(col_q + 1'b1);
        end
      end

      StClear: begin
        we   = 1'b1;
        addr = cell_addr(w_q, col_q);
        if (col_q == ColLast) begin
          col_d = '0;
          if (w_q == '0) begin
            state_d = StDone;
          end else begin
            w_d = w_q - 1'b1;
          end
        end else begin
          col_d = CW'(col_q + 1'b1);
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // Row finished (skipped, kept in place or copied): move up or wrap up the pass.
    if (advance) begin
      col_d = '0;
      if (r_q == '0) begin
        state_d = (lines_d != '0) ? StClear : StDone;
      end else begin
        r_d     = r_q - 1'b1;
        state_d = StRead;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      r_q       <= RowLast;
      w_q       <= RowLast;
      col_q     <= '0;
      lines_q   <= '0;
      row_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      w_q       <= w_d;
      col_q     <= col_d;
      lines_q   <= lines_d;
      row_buf_q <= row_buf_d;
    end
  end

  assign bus_io.mem_addr      = addr;
  assign bus_io.mem_we        = we;
  assign bus_io.mem_wdata     = wdata;
  assign bus_io.busy          = (state_q != StIdle);
  assign bus_io.done          = done;
  assign bus_io.lines_cleared = lines_q;

endmodule
